fetch_decode: RTL

Front-end stage of the 16-bit single-cycle processor. Fetches 16-bit instruction words from instruction memory over a request/acknowledge handshake and holds each in an instruction register. Splits the held word into the ALU-control inputs (`alu_op`, `func`), register addresses and a sign-extended immediate, then offers them downstream under a valid/ready handshake. Accepts branch/jump redirects from execute.

---
 rtl/fetch_decode.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_decode.sv
// Front-end fetch/decode stage: fetches one instruction word per request/ack
// handshake, holds it in ir and presents decoded fields under valid/ready.
module fetch_decode #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    // Reset value of the retired counter; nonzero only to exercise its wrap-around
    parameter logic [15:0] RETIRED_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [2:0]  alu_op,
    output logic [2:0]  func,
    output logic [2:0]  rs,
    output logic [2:0]  rt,
    output logic [2:0]  rd,
    output logic [15:0] imm,
    output logic [15:0] id_pc,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] id_pc_q, id_pc_d;
    logic [15:0] retired_q, retired_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            id_pc_q   <= 16'h0000;
            retired_q <= RETIRED_INIT;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            id_pc_q   <= id_pc_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        id_pc_d   = id_pc_q;
        retired_d = retired_q;
        imem_req  = 1'b0;
        id_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    id_pc_d = pc_q;
                    pc_d    = pc_q + 16'd1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                id_valid = 1'b1;
                if (id_ready) begin
                    retired_d = retired_q + 16'd1;
                    state_d   = run ? S_FETCH : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect overrides whatever the current state decided this cycle:
        // a same-cycle ack or acceptance is dropped, only the PC moves.
        if (br_taken) begin
            pc_d      = br_target;
            ir_d      = ir_q;
            id_pc_d   = id_pc_q;
            retired_d = retired_q;
            state_d   = run ? S_FETCH : S_IDLE;
        end
    end

    assign imem_addr = pc_q;
    assign id_pc     = id_pc_q;
    assign retired   = retired_q;

    assign alu_op = ir_q[15:13];
    assign rs     = ir_q[12:10];
    assign rt     = ir_q[9:7];
    assign rd     = ir_q[6:4];
    assign func   = ir_q[2:0];
    assign imm    = {{9{ir_q[6]}}, ir_q[6:0]};

    logic unused_ir_bit3;
    assign unused_ir_bit3 = ir_q[3];

endmodule
